// File: rtl/meas_responder_pkg.sv
// meas_responder_pkg: shared state encodings and default parameters for the measurement path.
package meas_responder_pkg;
    localparam int ADC_W        = 12;
    localparam int N_LOG2_DEF   = 8;
    localparam int TIMEOUT_DEF  = 4095;
    localparam int OUT_HOLD_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_READY   = 3'd2,
        ST_OUTPUT  = 3'd3
    } state_t;

    // Sequencer states of the TOP_FSM that issues meas_trigger/output_trigger
    typedef enum logic [1:0] {
        TOP_IDLE    = 2'd0,
        TOP_MEASURE = 2'd1,
        TOP_REPORT  = 2'd2
    } top_state_t;
endpackage

// File: rtl/meas_responder_if.sv
// meas_responder_if: trigger, ADC sample and result/status signals between TOP_FSM and the responder.
interface meas_responder_if;
    import meas_responder_pkg::*;
    logic             meas_trigger;
    logic             output_trigger;
    logic             adc_valid;
    logic [ADC_W-1:0] adc_data;
    logic             busy;
    logic             meas_done;
    logic             meas_err;
    logic [ADC_W-1:0] result;
    logic [ADC_W-1:0] peak;
    logic             result_valid;
    logic             out_done;
    logic [2:0]       state;

    modport master (
        output meas_trigger, output_trigger, adc_valid, adc_data,
        input  busy, meas_done, meas_err, result, peak, result_valid, out_done, state
    );
    modport slave (
        input  meas_trigger, output_trigger, adc_valid, adc_data,
        output busy, meas_done, meas_err, result, peak, result_valid, out_done, state
    );
endinterface

// File: rtl/meas_accum.sv
// meas_accum: running sum and maximum of ADC samples; sum/peak outputs already include the current sample.
module meas_accum
    import meas_responder_pkg::*;
#(
    parameter int N_LOG2 = N_LOG2_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    valid,
    input  logic [ADC_W-1:0]        data,
    output logic [ADC_W+N_LOG2-1:0] sum,
    output logic [ADC_W-1:0]        peak
);
    logic [ADC_W+N_LOG2-1:0] sum_q;
    logic [ADC_W-1:0]        peak_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            peak_q <= '0;
        end else if (clear) begin
            sum_q  <= '0;
            peak_q <= '0;
        end else if (valid) begin
            sum_q  <= sum;
            peak_q <= peak;
        end
    end

    always_comb begin
        sum  = valid ? sum_q + (ADC_W+N_LOG2)'(data) : sum_q;
        peak = valid && data > peak_q ? data : peak_q;
    end
endmodule

// File: rtl/meas_responder.sv
// meas_responder: averages 2^N_LOG2 ADC samples with idle timeout, then presents the result for OUT_HOLD cycles on request.
module meas_responder
    import meas_responder_pkg::*;
#(
    parameter int N_LOG2   = N_LOG2_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int OUT_HOLD = OUT_HOLD_DEF
) (
    input logic              clk,
    input logic              rst,
    meas_responder_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(OUT_HOLD + 1);

    state_t                  st, st_nx;
    logic [N_LOG2-1:0]       cnt;
    logic [TW-1:0]           tmo;
    logic [HW-1:0]           hold;
    logic [ADC_W+N_LOG2-1:0] sum;
    logic [ADC_W-1:0]        pk, result_q, peak_q;
    logic                    err_q, mdone_q, odone_q;
    logic                    start, take, last, expire, hold_end;

    assign start    = (st == ST_IDLE || st == ST_READY) && bus.meas_trigger;
    assign take     = st == ST_CAPTURE && bus.adc_valid;
    assign last     = take && &cnt;
    // Fires so meas_done lands on the TIMEOUT-th silent cycle after the last sample
    assign expire   = st == ST_CAPTURE && !bus.adc_valid && tmo == TW'(TIMEOUT - 2);
    assign hold_end = st == ST_OUTPUT && hold == HW'(OUT_HOLD - 1);

    meas_accum #(.N_LOG2(N_LOG2)) u_accum (
        .clk  (clk),
        .rst  (rst),
        .clear(start),
        .valid(take),
        .data (bus.adc_data),
        .sum  (sum),
        .peak (pk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= ST_IDLE;
        else     st <= st_nx;
    end

    always_comb begin
        st_nx = ST_IDLE;
        case (st)
            ST_IDLE:    st_nx = start ? ST_CAPTURE : ST_IDLE;
            ST_CAPTURE: st_nx = last || expire ? ST_READY : ST_CAPTURE;
            ST_READY:   st_nx = start ? ST_CAPTURE : bus.output_trigger ? ST_OUTPUT : ST_READY;
            ST_OUTPUT:  st_nx = hold_end ? ST_READY : ST_OUTPUT;
            default:    st_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            tmo      <= '0;
            hold     <= '0;
            result_q <= '0;
            peak_q   <= '0;
            err_q    <= 1'b0;
            mdone_q  <= 1'b0;
            odone_q  <= 1'b0;
        end else begin
            cnt      <= start ? '0 : take ? cnt + 1'b1 : cnt;
            tmo      <= start || take ? '0 : st == ST_CAPTURE ? tmo + 1'b1 : tmo;
            hold     <= st == ST_OUTPUT ? hold + 1'b1 : '0;
            err_q    <= start ? 1'b0 : expire ? 1'b1 : err_q;
            mdone_q  <= last || expire;
            odone_q  <= hold_end;
            result_q <= last ? ADC_W'(sum >> N_LOG2) : expire ? '0 : result_q;
            peak_q   <= last ? pk : expire ? '0 : peak_q;
        end
    end

    always_comb begin
        bus.busy         = st == ST_CAPTURE || st == ST_OUTPUT;
        bus.result_valid = st == ST_OUTPUT;
        bus.state        = st;
        bus.meas_done    = mdone_q;
        bus.meas_err     = err_q;
        bus.out_done     = odone_q;
        bus.result       = result_q;
        bus.peak         = peak_q;
    end
endmodule

// File: tb/tb_meas_responder.sv
// tb_meas_responder: directed scenarios for capture, timeout, output hold, trigger priority and reset recovery.
module tb_meas_responder;
    import meas_responder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    meas_responder_if bus();

    meas_responder #(.N_LOG2(2), .TIMEOUT(10), .OUT_HOLD(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic send(input logic [11:0] v);
        bus.adc_valid = 1'b1;
        bus.adc_data  = v;
        cyc();
        bus.adc_valid = 1'b0;
        bus.adc_data  = '0;
    endtask

    task automatic trig_meas();
        bus.meas_trigger = 1'b1;
        cyc();
        bus.meas_trigger = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        checks++;
        if ({bus.state, bus.busy, bus.meas_done, bus.meas_err, bus.result, bus.peak,
             bus.result_valid, bus.out_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: state=%0d busy=%b done=%b err=%b result=%0d peak=%0d rv=%b od=%b, all required 0",
                     bus.state, bus.busy, bus.meas_done, bus.meas_err, bus.result, bus.peak,
                     bus.result_valid, bus.out_done);
        end
        rst = 1'b0;
        bus.output_trigger = 1'b1;
        cyc();
        bus.output_trigger = 1'b0;
        checks++;
        if (bus.state !== 3'd0 || bus.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_output_ignored: state=%0d rv=%b, required 0/0", bus.state, bus.result_valid);
        end
    endtask

    task automatic test_capture();
        logic [11:0] s [4] = '{12'd100, 12'd200, 12'd300, 12'd403};
        trig_meas();
        checks++;
        if (bus.state !== 3'd1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL capture_entry: state=%0d busy=%b, required 1/1", bus.state, bus.busy);
        end
        for (int i = 0; i < 3; i++) begin
            send(s[i]);
            checks++;
            if (bus.meas_done !== 1'b0 || bus.state !== 3'd1) begin
                errors++;
                $display("FAIL capture_partial%0d: done=%b state=%0d, required 0/1", i, bus.meas_done, bus.state);
            end
        end
        send(s[3]);
        checks++;
        if (bus.meas_done !== 1'b1 || bus.state !== 3'd2) begin
            errors++;
            $display("FAIL capture_done: done=%b state=%0d, required 1/2", bus.meas_done, bus.state);
        end
        checks++;
        if (bus.result !== 12'd250 || bus.peak !== 12'd403 || bus.meas_err !== 1'b0) begin
            errors++;
            $display("FAIL capture_values: result=%0d peak=%0d err=%b, required 250/403/0", bus.result, bus.peak, bus.meas_err);
        end
        cyc();
        checks++;
        if (bus.meas_done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL capture_done_pulse: done=%b busy=%b, required 0/0", bus.meas_done, bus.busy);
        end
    endtask

    task automatic test_output();
        int rv_cnt = 0;
        int done_at = -1;
        bus.output_trigger = 1'b1;
        cyc();
        bus.output_trigger = 1'b0;
        checks++;
        if (bus.state !== 3'd3 || bus.result_valid !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL output_entry: state=%0d rv=%b busy=%b, required 3/1/1", bus.state, bus.result_valid, bus.busy);
        end
        for (int i = 0; i < 40; i++) begin
            if (bus.out_done === 1'b1) begin
                done_at = i;
                break;
            end
            if (bus.result_valid === 1'b1) rv_cnt++;
            bus.meas_trigger = (i == 5);
            cyc();
            bus.meas_trigger = 1'b0;
        end
        checks++;
        if (rv_cnt != 16 || done_at != 16) begin
            errors++;
            $display("FAIL output_hold: rv_cycles=%0d out_done_at=%0d, required 16/16", rv_cnt, done_at);
        end
        checks++;
        if (bus.state !== 3'd2 || bus.result_valid !== 1'b0 || bus.result !== 12'd250 || bus.peak !== 12'd403) begin
            errors++;
            $display("FAIL output_return: state=%0d rv=%b result=%0d peak=%0d, required 2/0/250/403",
                     bus.state, bus.result_valid, bus.result, bus.peak);
        end
        cyc();
        checks++;
        if (bus.out_done !== 1'b0) begin
            errors++;
            $display("FAIL output_done_pulse: out_done=%b, required 0", bus.out_done);
        end
    endtask

    task automatic test_timeout();
        int done_at = -1;
        trig_meas();
        send(12'd1000);
        send(12'd2000);
        for (int k = 1; k <= 30; k++) begin
            if (bus.meas_done === 1'b1) begin
                done_at = k;
                break;
            end
            if (k == 5) begin
                checks++;
                if (bus.state !== 3'd1) begin
                    errors++;
                    $display("FAIL timeout_ignore_output: state=%0d, required 1", bus.state);
                end
            end
            bus.output_trigger = (k == 3);
            cyc();
            bus.output_trigger = 1'b0;
        end
        checks++;
        if (done_at != 10) begin
            errors++;
            $display("FAIL timeout_latency: meas_done at cycle %0d after last sample, required 10", done_at);
        end
        checks++;
        if (bus.meas_err !== 1'b1 || bus.result !== 12'd0 || bus.peak !== 12'd0 || bus.state !== 3'd2) begin
            errors++;
            $display("FAIL timeout_values: err=%b result=%0d peak=%0d state=%0d, required 1/0/0/2",
                     bus.meas_err, bus.result, bus.peak, bus.state);
        end
    endtask

    task automatic test_simultaneous();
        bus.meas_trigger   = 1'b1;
        bus.output_trigger = 1'b1;
        cyc();
        bus.meas_trigger   = 1'b0;
        bus.output_trigger = 1'b0;
        checks++;
        if (bus.state !== 3'd1 || bus.result_valid !== 1'b0 || bus.meas_err !== 1'b0) begin
            errors++;
            $display("FAIL simultaneous_triggers: state=%0d rv=%b err=%b, required 1/0/0",
                     bus.state, bus.result_valid, bus.meas_err);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        send(12'd500);
        send(12'd600);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.state, bus.busy, bus.meas_done, bus.meas_err, bus.result, bus.peak,
             bus.result_valid, bus.out_done} !== '0) begin
            errors++;
            $display("FAIL reset_async: state=%0d busy=%b done=%b err=%b result=%0d peak=%0d, all required 0",
                     bus.state, bus.busy, bus.meas_done, bus.meas_err, bus.result, bus.peak);
        end
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (bus.meas_done !== 1'b0 || bus.state !== 3'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_discard: %0d cycles with meas_done or non-idle state, required 0", bad);
        end
    endtask

    task automatic test_full_scale();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        trig_meas();
        checks++;
        if (bus.state !== 3'd1) begin
            errors++;
            $display("FAIL first_edge_trigger: state=%0d, required 1", bus.state);
        end
        for (int i = 0; i < 4; i++) send(12'd4095);
        checks++;
        if (bus.meas_done !== 1'b1 || bus.result !== 12'd4095 || bus.peak !== 12'd4095 || bus.state !== 3'd2) begin
            errors++;
            $display("FAIL full_scale: done=%b result=%0d peak=%0d state=%0d, required 1/4095/4095/2",
                     bus.meas_done, bus.result, bus.peak, bus.state);
        end
    endtask

    initial begin
        bus.meas_trigger   = 1'b0;
        bus.output_trigger = 1'b0;
        bus.adc_valid      = 1'b0;
        bus.adc_data       = '0;
        test_reset();
        test_capture();
        test_output();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        test_full_scale();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/meas_responder.md
MEAS_RESPONDER -- requirements
Module: meas_responder

Interface
REQ-001 Parameter N_LOG2, default 8, log2 of samples averaged per measurement (legal range 1..10).
REQ-002 Parameter TIMEOUT, default 4095, maximum idle clk cycles between adc_valid pulses during capture.
REQ-003 Parameter OUT_HOLD, default 16, clk cycles result_valid stays high per output request.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 meas_trigger  input  1  one-cycle start-measurement pulse from TOP_FSM.
REQ-007 output_trigger  input  1  one-cycle start-output pulse from TOP_FSM.
REQ-008 adc_valid  input  1  sample strobe, at most one per cycle.
REQ-009 adc_data  input  12  unsigned ADC sample, qualified by adc_valid.
REQ-010 busy  output  1  high in CAPTURE and OUTPUT.
REQ-011 meas_done  output  1  one-cycle pulse when capture completes or times out.
REQ-012 meas_err  output  1  sticky timeout flag for the last measurement.
REQ-013 result  output  12  average of the last completed capture.
REQ-014 peak  output  12  maximum sample of the last completed capture.
REQ-015 result_valid  output  1  high during the OUTPUT hold window.
REQ-016 out_done  output  1  one-cycle pulse at end of OUTPUT.
REQ-017 state  output  3  current state encoding, for debug.

Function
REQ-018 States SHALL be IDLE=0, CAPTURE=1, READY=2, OUTPUT=3; other codes unreachable and SHALL recover to IDLE.
REQ-019 IDLE + meas_trigger -> CAPTURE on the next edge; accumulator, peak register, sample counter, timeout counter and meas_err SHALL be cleared on entry.
REQ-020 In CAPTURE each adc_valid SHALL add adc_data into a (12+N_LOG2)-bit accumulator, update peak if adc_data > peak, increment the sample counter and clear the timeout counter.
REQ-021 On the 2^N_LOG2-th accepted sample: result <= accumulator-including-that-sample >> N_LOG2 (truncating), peak latched, meas_done pulses one cycle later, state -> READY.
REQ-022 If TIMEOUT consecutive cycles pass in CAPTURE without adc_valid: meas_err <= 1, result <= 0, peak <= 0, meas_done pulses, state -> READY.
REQ-023 meas_trigger and output_trigger in CAPTURE or OUTPUT SHALL be ignored.
REQ-024 READY + meas_trigger SHALL restart CAPTURE per REQ-019; meas_trigger SHALL win over a simultaneous output_trigger.
REQ-025 READY + output_trigger -> OUTPUT: result_valid high for exactly OUT_HOLD cycles, then out_done pulses one cycle and state -> READY; result/peak unchanged.
REQ-026 output_trigger in IDLE SHALL be ignored; result_valid stays 0.
REQ-027 result and peak SHALL hold their values from completion until the next capture completes or times out.

Reset
REQ-028 rst SHALL asynchronously force state=IDLE, busy=0, meas_done=0, meas_err=0, result=0, peak=0, result_valid=0, out_done=0 and clear all counters and the accumulator.
REQ-029 rst asserted mid-CAPTURE or mid-OUTPUT SHALL discard the operation; no meas_done/out_done pulse follows release.
REQ-030 The first active edge after rst deassertion SHALL be able to accept meas_trigger.

Structure
REQ-031 State encodings and default N_LOG2/TIMEOUT/OUT_HOLD SHALL live in a shared package with the TOP_FSM state constants.
REQ-032 Accumulation/peak datapath SHALL be one sub-module, meas_accum (clear, valid, data in; sum, peak out); control FSM and counters stay in meas_responder.

Verification
REQ-033 N_LOG2=2, meas_trigger, 4 samples 100,200,300,403 -> meas_done one cycle after 4th, result=250, peak=403, state=2.
REQ-034 N_LOG2=2, TIMEOUT=10, meas_trigger, 2 samples then silence -> meas_done 10 cycles after last sample, meas_err=1, result=0.
REQ-035 From READY, output_trigger with OUT_HOLD=16 -> result_valid high exactly 16 cycles, out_done pulse on cycle 17, back to READY.
REQ-036 READY with meas_trigger and output_trigger in same cycle -> state=CAPTURE, result_valid stays 0.
REQ-037 rst pulsed after 2 of 4 samples -> all outputs 0, state=0, no meas_done afterwards; new capture of four 4095 samples -> result=4095, no accumulator overflow.
